regfile_mp_sb: RTL and testbench

- Parametrised successor to the core's 2-read/1-write integer register file.
- Configurable data width, register count and read-port count.
- x0 hardwired to zero; same-cycle write-to-read bypass.
- Sequential post-reset clear sequencer, so storage can map to RAM.
- Per-register pending (scoreboard) bits, so the pipelined decode stage can detect RAW hazards against in-flight writebacks.

---
 rtl/rf_defs.sv | 12 +
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/regfile_mp_sb.sv | 103 ++++++++++
 tb/tb_regfile_mp_sb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_defs.sv
// Shared defaults and sequencer state encoding for the multi-port register file.
package rf_defs;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage : rf_defs

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for RAW hazard detection, with per-port busy lookup.
module rf_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG),
    parameter int unsigned NRP  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NRP*AW-1:0] rd_addr,
    output logic [NRP-1:0]    rd_busy
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    // A new producer issuing on the same edge as a writeback supersedes it.
    always_comb begin
        pend_nxt = pend;
        for (int unsigned a = 1; a < NREG; a++) begin
            if (iss_en && (iss_addr == AW'(a))) begin
                pend_nxt[a] = 1'b1;
            end else if (wr_en && (wr_addr == AW'(a))) begin
                pend_nxt[a] = 1'b0;
            end
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend <= '0;
        end else if (run) begin
            pend <= pend_nxt;
        end
    end

    // A writeback landing this cycle is visible through the bypass, so it is not busy.
    always_comb begin
        rd_busy = '0;
        for (int unsigned i = 0; i < NRP; i++) begin
            rd_busy[i] = run && pend[rd_addr[i*AW +: AW]]
                         && !(wr_en && (wr_addr == rd_addr[i*AW +: AW]));
        end
    end

endmodule : rf_scoreboard

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-read-port integer register file with x0 tied to zero,
// write-to-read bypass, post-reset clear sequencer and pending-write scoreboard.
module regfile_mp_sb
    import rf_defs::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = $clog2(NREG),
    parameter int unsigned NRP  = 2
) (
    input  logic                clock,
    input  logic                reset,
    output logic                ready,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr
);

    localparam int unsigned CW = AW + 1;

    state_e          state;
    logic [CW-1:0]   clr_cnt;
    logic [XLEN-1:0] rf [NREG];
    logic            run;
    logic            arr_we;
    logic [AW-1:0]   arr_addr;
    logic [XLEN-1:0] arr_data;

    assign run = (state == ST_RUN);

    // Clear sequencer: one register per edge after reset, then RUN forever.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + CW'(1);
            if (clr_cnt == CW'(NREG - 1)) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end
        end
    end

    // Single array write port shared by the clear sequencer and writeback.
    always_comb begin
        arr_we   = 1'b0;
        arr_addr = wr_addr;
        arr_data = wr_data;
        if (!reset) begin
            if (!run) begin
                arr_we   = 1'b1;
                arr_addr = clr_cnt[AW-1:0];
                arr_data = '0;
            end else if (wr_en && (wr_addr != '0)) begin
                arr_we = 1'b1;
            end
        end
    end

    // No reset on storage so it can map onto a RAM macro.
    always_ff @(posedge clock) begin
        if (arr_we) begin
            rf[arr_addr] <= arr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NRP; i++) begin
            if (run && (rd_addr[i*AW +: AW] != '0)) begin
                if (wr_en && (wr_addr == rd_addr[i*AW +: AW])) begin
                    rd_data[i*XLEN +: XLEN] = wr_data;
                end else begin
                    rd_data[i*XLEN +: XLEN] = rf[rd_addr[i*AW +: AW]];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NRP  (NRP)
    ) u_sb (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule : regfile_mp_sb

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb (4 read ports) against a per-cycle behavioural model.
module tb_regfile_mp_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRP  = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                ready;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                wr_en = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [XLEN-1:0]     wr_data = '0;
    logic                iss_en = 1'b0;
    logic [AW-1:0]       iss_addr = '0;
    logic [AW-1:0]       ra [NRP];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: register values as the program sees them, pending flags, clear progress.
    logic [XLEN-1:0] m_rf [NREG];
    bit              m_pend [NREG];
    bit              m_run = 1'b0;
    bit              valid = 1'b0;
    int              m_cnt = 0;

    assign rd_addr = {ra[3], ra[2], ra[1], ra[0]};

    always #5 clock = ~clock;

    regfile_mp_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW),
        .NRP  (NRP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ready    (ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] port_data(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    // Sample on the falling edge and compare every output against the model.
    task automatic sample();
        logic [XLEN-1:0] ed;
        logic            eb;
        @(negedge clock);
        if (valid) begin
            chk("ready", 32'(ready), 32'(m_run));
            for (int p = 0; p < int'(NRP); p++) begin
                ed = '0;
                eb = 1'b0;
                if (m_run && ra[p] != 0) begin
                    ed = (wr_en && wr_addr == ra[p]) ? wr_data : m_rf[ra[p]];
                    eb = m_pend[ra[p]] && !(wr_en && wr_addr == ra[p]);
                end
                chk($sformatf("rd_data%0d", p), port_data(p), ed);
                chk($sformatf("rd_busy%0d", p), 32'(rd_busy[p]), 32'(eb));
            end
        end
    endtask

    // Advance one clock edge and apply its architectural effect to the model.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            valid = 1'b1;
            m_run = 1'b0;
            m_cnt = 0;
            for (int r = 0; r < int'(NREG); r++) begin
                m_rf[r]   = '0;
                m_pend[r] = 1'b0;
            end
        end else if (!m_run) begin
            m_cnt++;
            if (m_cnt == int'(NREG)) m_run = 1'b1;
        end else begin
            if (wr_en && wr_addr != 0) m_rf[wr_addr] = wr_data;
            if (wr_en) m_pend[wr_addr] = 1'b0;
            if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < int'(NRP); p++) ra[p] = '0;

        repeat (3) step();
        reset = 1'b0;

        // Writes offered during the clear must be ignored.
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hDEADBEEF;
        iss_en  = 1'b1;
        iss_addr = 5'd5;
        for (int k = 0; k < int'(NREG); k++) begin
            sample();
            if (k == 0 || k == int'(NREG) - 1) chk("ready_during_clear", 32'(ready), 32'd0);
            tick();
        end
        idle();
        sample();
        chk("ready_after_clear", 32'(ready), 32'd1);
        tick();

        for (int r = 0; r < int'(NREG); r++) begin
            for (int p = 0; p < int'(NRP); p++) ra[p] = AW'((r + p) % int'(NREG));
            sample();
            if (r == 5) begin
                chk("x5_after_clear", port_data(0), 32'd0);
                chk("x5_not_busy", 32'(rd_busy[0]), 32'd0);
            end
            tick();
        end

        // Bypass then array read of x7.
        ra[0] = 5'd7; ra[1] = 5'd7; ra[2] = 5'd1; ra[3] = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        sample();
        chk("x7_bypass", port_data(0), 32'h12345678);
        tick();
        idle();
        sample();
        chk("x7_array", port_data(0), 32'h12345678);
        tick();

        // Write and issue to x0 have no effect.
        for (int p = 0; p < int'(NRP); p++) ra[p] = '0;
        wr_en = 1'b1; wr_addr = '0; wr_data = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = '0;
        step();
        idle();
        sample();
        chk("x0_data", port_data(0), 32'd0);
        chk("x0_busy", 32'(rd_busy[1]), 32'd0);
        tick();

        // Issue x3, retire it four cycles later.
        ra[0] = 5'd3; ra[1] = 5'd9;
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        idle();
        sample();
        chk("x3_busy_t1", 32'(rd_busy[0]), 32'd1);
        tick();
        step();
        step();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000033;
        sample();
        chk("x3_busy_bypass", 32'(rd_busy[0]), 32'd0);
        chk("x3_data_bypass", port_data(0), 32'h33);
        tick();
        idle();
        sample();
        chk("x3_busy_after", 32'(rd_busy[0]), 32'd0);
        tick();

        // Issue and writeback to x9 on the same edge: issue wins.
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        step();
        idle();
        sample();
        chk("x9_set_wins", 32'(rd_busy[1]), 32'd1);
        chk("x9_data", port_data(1), 32'h99);
        tick();

        // Re-issue while pending and read in same cycle: stays busy.
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        idle();

        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5A5A5;
        step();
        idle();
        ra[0] = 5'd2; ra[1] = 5'd2; ra[2] = 5'd31; ra[3] = 5'd0;
        sample();
        chk("p0_x2", port_data(0), 32'd0);
        chk("p1_x2", port_data(1), 32'd0);
        chk("p2_x31", port_data(2), 32'hA5A5A5A5);
        chk("p3_x0", port_data(3), 32'd0);
        tick();

        // Reset in the middle of RUN with x4 live and pending.
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
        step();
        idle();
        iss_en = 1'b1; iss_addr = 5'd4;
        step();
        idle();
        ra[0] = 5'd4; ra[1] = 5'd4; ra[2] = 5'd9; ra[3] = 5'd31;
        sample();
        chk("x4_pre_data", port_data(0), 32'h55);
        chk("x4_pre_busy", 32'(rd_busy[0]), 32'd1);
        tick();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sample();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(rd_busy[0]), 32'd0);
        tick();
        for (int k = 1; k < int'(NREG); k++) step();
        sample();
        chk("rerun_ready", 32'(ready), 32'd1);
        chk("x4_cleared", port_data(0), 32'd0);
        chk("x4_not_busy", 32'(rd_busy[0]), 32'd0);
        tick();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp_sb
